gf163_sqrt_iter: RTL and testbench

GF163_SQRT_ITER -- requirements
Module: gf163_sqrt_iter

---
 rtl/gf163_sqrt_iter.sv | 116 +++++++++++
 tb/tb_gf163_sqrt_iter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/gf163_sqrt_iter.sv
// Iterative k-fold square root in GF(2^163), f(x) = x^163 + x^7 + x^6 + x^3 + 1.
// Define SQRT_DOUBLE_STEP_EN to take two roots per cycle while two or more remain.
module gf163_sqrt_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [7:0]   k,
    input  logic [162:0] a,
    output logic         busy,
    output logic         done,
    output logic [162:0] b
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [162:0] RED = 163'h0C9;

    // sqrt(x) = x^5 + sum x^(4+3j), j=0..25 + sum x^(9+3j), j=0..51
    function automatic logic [162:0] sqrt_x_poly();
        logic [162:0] s;
        s    = '0;
        s[5] = 1'b1;
        for (int i = 4; i <= 79; i += 3) s[i] = 1'b1;
        for (int i = 9; i <= 162; i += 3) s[i] = 1'b1;
        return s;
    endfunction

    localparam logic [162:0] SQRT_X = sqrt_x_poly();

    function automatic logic [162:0] mulx(input logic [162:0] v);
        return {v[161:0], 1'b0} ^ (RED & {163{v[162]}});
    endfunction

    // sqrt(v) = v_even(x) + sqrt(x) * v_odd(x), the halves taken from alternate bits
    function automatic logic [162:0] gf_sqrt(input logic [162:0] v);
        logic [162:0] r;
        logic [162:0] p;
        r = '0;
        p = SQRT_X;
        for (int i = 0; i < 82; i++) r[i] = v[2*i];
        for (int i = 0; i < 81; i++) begin
            if (v[2*i+1]) r = r ^ p;
            p = mulx(p);
        end
        return r;
    endfunction

    state_t       state, state_n;
    logic [162:0] acc, acc_n, b_n;
    logic [7:0]   cnt, cnt_n;
    logic         done_n;
    logic [162:0] sq1;

    assign sq1  = gf_sqrt(acc);
    assign busy = (state == RUN);

`ifdef SQRT_DOUBLE_STEP_EN
    logic [162:0] sq2;
    assign sq2 = gf_sqrt(sq1);
`endif

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        b_n     = b;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_n   = a;
                    cnt_n   = k;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (cnt == 8'd0) begin
                    b_n     = acc;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
`ifdef SQRT_DOUBLE_STEP_EN
                    if (cnt >= 8'd2) begin
                        acc_n = sq2;
                        cnt_n = cnt - 8'd2;
                    end else begin
                        acc_n = sq1;
                        cnt_n = cnt - 8'd1;
                    end
`else
                    acc_n = sq1;
                    cnt_n = cnt - 8'd1;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            b     <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            b     <= b_n;
            done  <= done_n;
        end
    end

endmodule

// File: tb/tb_gf163_sqrt_iter.sv
// Bench for gf163_sqrt_iter: hand-derived vectors, corner sequences and squaring-model checks.
module tb_gf163_sqrt_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [7:0]   k;
    logic [162:0] a;
    logic         busy;
    logic         done;
    logic [162:0] b;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [162:0] a;
        logic [7:0]   k;
        logic [162:0] b;
    } vec_t;

    always #5 clk = ~clk;

    gf163_sqrt_iter dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .k     (k),
        .a     (a),
        .busy  (busy),
        .done  (done),
        .b     (b)
    );

    // Reference squaring: spread bits, then fold x^i (i >= 163) down via f
    function automatic logic [162:0] gf_square(input logic [162:0] v);
        logic [324:0] t;
        t = '0;
        for (int i = 0; i < 163; i++) t[2*i] = v[i];
        for (int i = 324; i >= 163; i--) begin
            if (t[i]) begin
                t[i]     = 1'b0;
                t[i-163] = ~t[i-163];
                t[i-160] = ~t[i-160];
                t[i-157] = ~t[i-157];
                t[i-156] = ~t[i-156];
            end
        end
        return t[162:0];
    endfunction

    function automatic int exp_latency(input int kk);
`ifdef SQRT_DOUBLE_STEP_EN
        return (kk + 1) / 2 + 1;
`else
        return kk + 1;
`endif
    endfunction

    task automatic check_output(input string name, input logic [162:0] actual,
                                input logic [162:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Called #1 after a rising edge; returns b and the number of edges until done
    task automatic apply_stimulus(input logic [162:0] av, input logic [7:0] kv,
                                  output logic [162:0] bv, output int lat);
        start = 1'b1;
        a     = av;
        k     = kv;
        @(posedge clk); #1;
        start = 1'b0;
        a     = ~av;
        k     = ~kv;
        check_output("busy_after_start", 163'(busy), 163'd1);
        lat = 0;
        while (!done && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) check_output("done_timeout", 163'(done), 163'd1);
        bv = b;
    endtask

    vec_t         vecs [10];
    logic [162:0] res, model, pat, rnd0, held_b;
    logic [191:0] wide;
    logic [7:0]   rk;
    int           lat, ndone;

    initial begin
        pat  = {3'b010, {20{8'h5A}}};
        rnd0 = {3'b101, {5{32'hC3E1_7B29}}};
        vecs[0] = '{163'd1,          8'd5,   163'd1};
        vecs[1] = '{163'd1 << 4,     8'd2,   163'd1 << 1};
        vecs[2] = '{163'd1 << 2,     8'd1,   163'd1 << 1};
        vecs[3] = '{pat,             8'd163, pat};
        vecs[4] = '{rnd0,            8'd0,   rnd0};
        vecs[5] = '{163'd1 << 8,     8'd3,   163'd1 << 1};
        vecs[6] = '{163'd1 << 160,   8'd5,   163'd1 << 5};
        vecs[7] = '{163'd0,          8'd200, 163'd0};
        vecs[8] = '{163'd1 << 128,   8'd7,   163'd1 << 1};
        vecs[9] = '{163'd1 << 162,   8'd1,   163'd1 << 81};

        rst   = 1'b1;
        start = 1'b0;
        k     = '0;
        a     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_busy", 163'(busy), 163'd0);
        check_output("reset_done", 163'(done), 163'd0);
        check_output("reset_b", b, 163'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Consecutive calls start in the done cycle, exercising back-to-back issue
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i].a, vecs[i].k, res, lat);
            check_output($sformatf("vec%0d_b", i), res, vecs[i].b);
            check_output($sformatf("vec%0d_latency", i), 163'(lat),
                         163'(exp_latency(int'(vecs[i].k))));
            check_output($sformatf("vec%0d_busy_at_done", i), 163'(busy), 163'd0);
        end
        @(posedge clk); #1;
        check_output("done_pulse_width", 163'(done), 163'd0);

        // A start while busy must be ignored
        start = 1'b1;
        a     = 163'd1 << 2;
        k     = 8'd1;
        @(posedge clk); #1;
        a     = 163'd1;
        k     = 8'd0;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        held_b = '0;
        for (int c = 0; c < 6; c++) begin
            if (done) begin
                ndone++;
                held_b = b;
            end
            @(posedge clk); #1;
        end
        check_output("ignored_start_done_count", 163'(ndone), 163'd1);
        check_output("ignored_start_b", held_b, 163'd1 << 1);

        // Reset in the middle of a k=10 run aborts it without a done
        start = 1'b1;
        a     = 163'd1 << 4;
        k     = 8'd10;
        @(posedge clk); #1;
        start = 1'b0;
        check_output("b_held_while_busy", b, 163'd1 << 1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_output("abort_busy", 163'(busy), 163'd0);
        check_output("abort_done", 163'(done), 163'd0);
        check_output("abort_b", b, 163'd0);
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            if (done) ndone++;
            @(posedge clk); #1;
        end
        check_output("abort_no_done", 163'(ndone), 163'd0);

        apply_stimulus(163'd1 << 2, 8'd1, res, lat);
        check_output("post_reset_b", res, 163'd1 << 1);
        check_output("post_reset_latency", 163'(lat), 163'(exp_latency(1)));
        @(posedge clk); #1;

        // Random operands: squaring the result k times must give back a
        for (int i = 0; i < 6; i++) begin
            wide = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rk   = 8'($urandom_range(0, 255));
            apply_stimulus(wide[162:0], rk, res, lat);
            model = res;
            repeat (int'(rk)) model = gf_square(model);
            check_output($sformatf("rand%0d_model", i), model, wide[162:0]);
            check_output($sformatf("rand%0d_latency", i), 163'(lat),
                         163'(exp_latency(int'(rk))));
            @(posedge clk); #1;
            check_output($sformatf("rand%0d_pulse_width", i), 163'(done), 163'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
